sdp_ram_fifo_ctrl: RTL and testbench

- Single-clock FIFO controller that drives one external simple dual-port RAM: write address/enable, read address/enable, return data.
- Presents valid/ready streams on both sides.
- Hides the RAM read latency (1 or 2 cycles, matching the RAM's output register setting) with an internal prefetch buffer, so throughput is one word per cycle.
- Used in the DSI TX path for pixel/line buffering between the video source and the packetiser.

---
 rtl/sdp_ram_fifo_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_sdp_ram_fifo_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdp_ram_fifo_ctrl.sv
// sdp_ram_fifo_ctrl
//   Single-clock FIFO controller for an external simple dual-port RAM.
//   Both sides use valid/ready streams. A small circular prefetch buffer of
//   RAM_LATENCY+1 words hides the RAM read latency, so the FIFO sustains
//   one word per cycle. RAM_LATENCY is 1 (RAM output register off) or
//   2 (RAM output register on).
//
//   Optional build macro:
//     SDP_FIFO_FLUSH_EN - adds a synchronous, active-high 'flush' input.
//       A flush clears the pointers, the counters and the prefetch buffer.
//       Reads that are still in flight are dropped when they return.
//       Without the macro, only rst_n clears state.
module sdp_ram_fifo_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 9,
  parameter int RAM_LATENCY = 2,
  parameter int AFULL_LEVEL = 2**ADDR_WIDTH - 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_re,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [ADDR_WIDTH+1:0] level,
  output logic                  almost_full
`ifdef SDP_FIFO_FLUSH_EN
  ,
  input  logic                  flush
`endif
);

  localparam int DEPTH     = 2**ADDR_WIDTH;
  localparam int BUF_DEPTH = RAM_LATENCY + 1;
  localparam int BUF_AW    = $clog2(BUF_DEPTH);
  localparam int CNT_W     = ADDR_WIDTH + 1;
  localparam int LVL_W     = ADDR_WIDTH + 2;

  localparam logic [CNT_W-1:0]  RAM_FULL  = CNT_W'(DEPTH);
  localparam logic [LVL_W-1:0]  BUF_FULL  = LVL_W'(BUF_DEPTH);
  localparam logic [LVL_W-1:0]  AFULL_THR = LVL_W'(AFULL_LEVEL);
  localparam logic [BUF_AW-1:0] BUF_LAST  = BUF_AW'(BUF_DEPTH - 1);

  // Counts the outstanding reads held in the in-flight valid shift register.
  function automatic logic [LVL_W-1:0] count_ones(input logic [RAM_LATENCY-1:0] v);
    logic [LVL_W-1:0] n;
    n = '0;
    for (int i = 0; i < RAM_LATENCY; i++) n = n + LVL_W'(v[i]);
    return n;
  endfunction

  // Advances a circular pointer for the prefetch buffer. The depth does not
  // have to be a power of two.
  function automatic logic [BUF_AW-1:0] buf_inc(input logic [BUF_AW-1:0] p);
    return (p == BUF_LAST) ? '0 : p + 1'b1;
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0]  wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0]  rptr_q, rptr_d;
  logic [CNT_W-1:0]       ram_cnt_q, ram_cnt_d;
  logic [RAM_LATENCY-1:0] vld_q, vld_d;
  logic [BUF_AW-1:0]      buf_head_q, buf_head_d;
  logic [BUF_AW-1:0]      buf_tail_q, buf_tail_d;
  logic [BUF_AW:0]        buf_cnt_q, buf_cnt_d;
  logic [DATA_WIDTH-1:0]  buf_mem_q [BUF_DEPTH];
  logic                   almost_full_q, almost_full_d;
  logic [LVL_W-1:0]       level_d;

  logic                   flush_w;
  logic                   wr_acc;
  logic                   issue;
  logic                   push;
  logic                   pop;
  logic [LVL_W-1:0]       inflight;
  logic [LVL_W-1:0]       occ;

`ifdef SDP_FIFO_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Write side: the RAM write is a pass-through of the accepted beat.
  // s_ready depends only on registered state (and on flush), never on
  // m_ready. It stays low while reset is asserted.
  // ---------------------------------------------------------------------
  assign s_ready   = rst_n & ((ram_cnt_q != RAM_FULL) | flush_w);
  assign wr_acc    = s_valid & s_ready & ~flush_w;
  assign ram_we    = wr_acc;
  assign ram_waddr = wptr_q;
  assign ram_wdata = s_data;

  // ---------------------------------------------------------------------
  // Read side: the prefetch buffer feeds the consumer.
  // ---------------------------------------------------------------------
  assign m_valid = (buf_cnt_q != '0);
  assign m_data  = buf_mem_q[buf_head_q];
  assign pop     = m_valid & m_ready & ~flush_w;
  assign push    = vld_q[RAM_LATENCY-1] & ~flush_w;

  // A read may issue only if every word that could land in the buffer
  // still has a slot there. The slots are the words in flight plus the
  // words buffered. A word popped this cycle frees its slot at the same
  // edge, so the limit is raised by one when a pop happens. Without that,
  // steady streaming would stall on every other cycle.
  assign inflight  = count_ones(vld_q);
  assign occ       = inflight + LVL_W'(buf_cnt_q);
  assign issue     = (ram_cnt_q != '0) & (occ < (BUF_FULL + LVL_W'(pop))) & ~flush_w;
  assign ram_re    = issue;
  assign ram_raddr = rptr_q;

  assign level       = LVL_W'(ram_cnt_q) + occ;
  assign almost_full = almost_full_q;

  // Next-state logic for the pointers, the counters and the in-flight tracker.
  // NOTE: always_comb uses blocking '=' and gives every output a default
  // value first, so no path can leave a signal unassigned and infer a latch.
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    ram_cnt_d  = ram_cnt_q;
    buf_head_d = buf_head_q;
    buf_tail_d = buf_tail_q;
    buf_cnt_d  = buf_cnt_q;
    // The RAM output pipeline advances every clock, so the valid shift
    // register advances every clock as well and never stalls.
    vld_d      = RAM_LATENCY'({vld_q, issue});

    if (wr_acc) wptr_d = wptr_q + 1'b1;
    if (issue)  rptr_d = rptr_q + 1'b1;

    case ({wr_acc, issue})
      2'b10:   ram_cnt_d = ram_cnt_q + 1'b1;
      2'b01:   ram_cnt_d = ram_cnt_q - 1'b1;
      default: ram_cnt_d = ram_cnt_q;
    endcase

    if (push) buf_tail_d = buf_inc(buf_tail_q);
    if (pop)  buf_head_d = buf_inc(buf_head_q);

    case ({push, pop})
      2'b10:   buf_cnt_d = buf_cnt_q + 1'b1;
      2'b01:   buf_cnt_d = buf_cnt_q - 1'b1;
      default: buf_cnt_d = buf_cnt_q;
    endcase

    // Clearing the in-flight valid bits marks the outstanding reads as
    // stale. Their data still returns from the RAM, but it is never pushed.
    if (flush_w) begin
      wptr_d     = '0;
      rptr_d     = '0;
      ram_cnt_d  = '0;
      vld_d      = '0;
      buf_head_d = '0;
      buf_tail_d = '0;
      buf_cnt_d  = '0;
    end
  end

  // The next level is computed ahead of the edge, so the registered
  // almost_full flag lines up with the level it describes.
  always_comb begin
    level_d       = LVL_W'(ram_cnt_d) + count_ones(vld_d) + LVL_W'(buf_cnt_d);
    almost_full_d = (level_d >= AFULL_THR);
  end

  // Control registers: pointers, counters, the in-flight tracker and the flag.
  // NOTE: sequential state uses non-blocking '<=' so that every register
  // samples values from before the edge, whatever order the statements run in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q        <= '0;
      rptr_q        <= '0;
      ram_cnt_q     <= '0;
      vld_q         <= '0;
      buf_head_q    <= '0;
      buf_tail_q    <= '0;
      buf_cnt_q     <= '0;
      almost_full_q <= 1'b0;
    end else begin
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      ram_cnt_q     <= ram_cnt_d;
      vld_q         <= vld_d;
      buf_head_q    <= buf_head_d;
      buf_tail_q    <= buf_tail_d;
      buf_cnt_q     <= buf_cnt_d;
      almost_full_q <= almost_full_d;
    end
  end

  // Prefetch buffer storage. Returning RAM data is captured at the tail.
  // NOTE: this small array is reset on purpose so that m_data reads 0
  // during reset. Large RAM-style arrays are normally left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) buf_mem_q[i] <= '0;
    end else if (push) begin
      buf_mem_q[buf_tail_q] <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_sdp_ram_fifo_ctrl.sv
// Testbench for sdp_ram_fifo_ctrl.
//   Instance A: ADDR_WIDTH=4, RAM_LATENCY=2.
//   Instance B: ADDR_WIDTH=4, RAM_LATENCY=1.
//   Each instance has its own behavioural simple dual-port RAM.
//   Define SDP_FIFO_FLUSH_EN to exercise the flush input as well.
module tb_sdp_ram_fifo_ctrl;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int D  = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A signals (RAM_LATENCY = 2)
  logic          s_valid, s_ready, m_valid, m_ready, ram_we, ram_re, almost_full;
  logic [DW-1:0] s_data, m_data, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [AW+1:0] level;

  // Instance B signals (RAM_LATENCY = 1)
  logic          s_valid_b, s_ready_b, m_valid_b, m_ready_b, ram_we_b, ram_re_b, almost_full_b;
  logic [DW-1:0] s_data_b, m_data_b, ram_wdata_b, ram_rdata_b;
  logic [AW-1:0] ram_waddr_b, ram_raddr_b;
  logic [AW+1:0] level_b;

`ifdef SDP_FIFO_FLUSH_EN
  logic flush;
  logic flush_b;
`endif

  int checks = 0;
  int errors = 0;

  sdp_ram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_LATENCY(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_re(ram_re), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
    .level(level), .almost_full(almost_full)
`ifdef SDP_FIFO_FLUSH_EN
    , .flush(flush)
`endif
  );

  sdp_ram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_LATENCY(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid_b), .s_ready(s_ready_b), .s_data(s_data_b),
    .m_valid(m_valid_b), .m_ready(m_ready_b), .m_data(m_data_b),
    .ram_we(ram_we_b), .ram_waddr(ram_waddr_b), .ram_wdata(ram_wdata_b),
    .ram_re(ram_re_b), .ram_raddr(ram_raddr_b), .ram_rdata(ram_rdata_b),
    .level(level_b), .almost_full(almost_full_b)
`ifdef SDP_FIFO_FLUSH_EN
    , .flush(flush_b)
`endif
  );

  // RAM for instance A: registered read plus an output register
  // (two-cycle read latency).
  logic [DW-1:0] mem_a [D];
  logic [DW-1:0] rd1_a, rd2_a;
  always @(posedge clk) begin
    if (ram_we) mem_a[ram_waddr] <= ram_wdata;
    if (ram_re) rd1_a <= mem_a[ram_raddr];
    rd2_a <= rd1_a;
  end
  assign ram_rdata = rd2_a;

  // RAM for instance B: registered read only (one-cycle read latency).
  logic [DW-1:0] mem_b [D];
  logic [DW-1:0] rd1_b;
  always @(posedge clk) begin
    if (ram_we_b) mem_b[ram_waddr_b] <= ram_wdata_b;
    if (ram_re_b) rd1_b <= mem_b[ram_raddr_b];
  end
  assign ram_rdata_b = rd1_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns one time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fills A with words 0..9 while m_ready=0, then writes 10 and 11 while
  // popping 0 and 1. The end state is RAM 7, two reads in flight and one
  // word buffered, for a level of 10.
  task automatic load_ten_two_inflight();
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'b1;
      s_data  = DW'(i);
      tick();
    end
    s_valid = 1'b0;
    tick();
    tick();
    check("ld_level10", level, 10);
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1;
      s_data  = DW'(10 + i);
      m_ready = 1'b1;
      #1;
      check("ld_pop_data", m_data, i);
      check("ld_issue", ram_re, 1);
      tick();
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    check("ld_level_pre", level, 10);
  endtask

  // Writes 0x3C into an empty A and checks it is the first word out,
  // three edges after the accept.
  task automatic first_word_3c(input string tag);
    int n;
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h3C;
    tick();
    s_valid = 1'b0;
    n = 0;
    while (!m_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, n, 3);
    check({tag, "_data"}, m_data, 8'h3C);
    tick();
    check({tag, "_empty"}, level, 0);
    m_ready = 1'b0;
  endtask

  initial begin
    int n, acc, exp_w, widx, ridx, first, last, lvl;
    logic          acc_now, pop_now;
    logic [DW-1:0] wdat;
    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_head;

    s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    s_valid_b = 1'b0; s_data_b = '0; m_ready_b = 1'b0;
`ifdef SDP_FIFO_FLUSH_EN
    flush = 1'b0; flush_b = 1'b0;
`endif
    rst_n = 1'b0;

    // ---- Reset values. s_valid is held high to show that writes are blocked.
    #12;
    s_valid = 1'b1;
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_level", level, 0);
    check("rst_afull", almost_full, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_re", ram_re, 0);
    check("rst_waddr", ram_waddr, 0);
    check("rst_raddr", ram_raddr, 0);
    s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_s_ready", s_ready, 1);
    tick();

    // ---- Single write of 0xA5: m_valid three edges after the accept.
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'hA5;
    #1;
    check("wr_we", ram_we, 1);
    check("wr_waddr", ram_waddr, 0);
    check("wr_wdata", ram_wdata, 8'hA5);
    tick();
    s_valid = 1'b0;
    check("one_level", level, 1);
    n = 0;
    while (!m_valid && n < 20) begin
      tick();
      n++;
    end
    check("one_latency", n, 3);
    check("one_data", m_data, 8'hA5);
    check("one_level_buf", level, 1);
    tick();
    check("one_popped_valid", m_valid, 0);
    check("one_popped_level", level, 0);

    // ---- Fill with m_ready=0: capacity is 16 + 2 + 1 = 19.
    m_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 22; c++) begin
      s_valid = 1'b1;
      s_data  = DW'(acc);
      #1;
      check("fill_ready", s_ready, acc < 19);
      tick();
      if (acc < 19) acc++;
      check("fill_level", level, acc);
      check("fill_afull", almost_full, acc >= 12);
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    exp_w = 0;
    for (int c = 0; c < 60 && exp_w < 19; c++) begin
      if (m_valid) begin
        check("drain_data", m_data, exp_w);
        exp_w++;
      end
      tick();
    end
    check("drain_count", exp_w, 19);
    check("drain_level", level, 0);
    check("drain_afull", almost_full, 0);

    // ---- Stream 100 words with m_ready=1: in order, one word per cycle.
    widx = 0; ridx = 0; first = -1; last = -1;
    for (int c = 0; c < 160 && ridx < 100; c++) begin
      s_valid = (widx < 100);
      s_data  = DW'(widx);
      #1;
      if (widx < 100) check("strm_ready", s_ready, 1);
      if (m_valid) begin
        check("strm_data", m_data, DW'(ridx));
        if (first < 0) first = c;
        last = c;
        ridx++;
      end
      acc_now = s_valid & s_ready;
      tick();
      if (acc_now) widx++;
    end
    s_valid = 1'b0;
    check("strm_count", ridx, 100);
    check("strm_rate", last - first, 99);
    check("strm_level", level, 0);

    // ---- Random traffic on A, checked against a scoreboard.
    lvl = 0;
    for (int c = 0; c < 2000; c++) begin
      wdat    = DW'($urandom);
      s_valid = ($urandom_range(1, 0) == 1);
      s_data  = wdat;
      m_ready = ($urandom_range(1, 0) == 1);
      #1;
      if (lvl < D) check("rnd_ready_hi", s_ready, 1);
      if (lvl == D + 3) check("rnd_ready_full", s_ready, 0);
      pop_now = m_valid & m_ready;
      if (m_valid) begin
        exp_head = (q.size() > 0) ? q[0] : 'x;
        check("rnd_data", m_data, exp_head);
      end
      if (pop_now && q.size() > 0) void'(q.pop_front());
      acc_now = s_valid & s_ready;
      tick();
      if (acc_now) q.push_back(wdat);
      lvl = lvl + (acc_now ? 1 : 0) - (pop_now ? 1 : 0);
      check("rnd_level", level, lvl);
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int c = 0; c < 80 && q.size() > 0; c++) begin
      if (m_valid) begin
        check("rnd_drain_data", m_data, q[0]);
        void'(q.pop_front());
      end
      tick();
    end
    check("rnd_drain_left", q.size(), 0);
    check("rnd_drain_level", level, 0);
    m_ready = 1'b0;

    // ---- Instance B (RAM_LATENCY=1): latency of 2 edges, capacity of 18.
    m_ready_b = 1'b1;
    s_valid_b = 1'b1;
    s_data_b  = 8'h11;
    tick();
    s_valid_b = 1'b0;
    n = 0;
    while (!m_valid_b && n < 20) begin
      tick();
      n++;
    end
    check("b_latency", n, 2);
    check("b_data", m_data_b, 8'h11);
    tick();
    check("b_level0", level_b, 0);
    m_ready_b = 1'b0;
    acc = 0;
    for (int c = 0; c < 21; c++) begin
      s_valid_b = 1'b1;
      s_data_b  = DW'(acc + 8'h40);
      #1;
      check("b_fill_ready", s_ready_b, acc < 18);
      tick();
      if (acc < 18) acc++;
      check("b_fill_level", level_b, acc);
    end
    s_valid_b = 1'b0;
    m_ready_b = 1'b1;
    exp_w = 0;
    for (int c = 0; c < 60 && exp_w < 18; c++) begin
      if (m_valid_b) begin
        check("b_drain_data", m_data_b, exp_w + 8'h40);
        exp_w++;
      end
      tick();
    end
    check("b_drain_count", exp_w, 18);
    check("b_drain_level", level_b, 0);
    m_ready_b = 1'b0;

    // ---- Reset with 10 words held and 2 reads in flight.
    load_ten_two_inflight();
    s_valid = 1'b1;
    s_data  = 8'hEE;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", m_valid, 0);
    check("mid_rst_data", m_data, 0);
    check("mid_rst_level", level, 0);
    check("mid_rst_we", ram_we, 0);
    check("mid_rst_re", ram_re, 0);
    check("mid_rst_waddr", ram_waddr, 0);
    check("mid_rst_raddr", ram_raddr, 0);
    check("mid_rst_afull", almost_full, 0);
    s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    first_word_3c("after_rst");

`ifdef SDP_FIFO_FLUSH_EN
    // ---- The same scenario, cleared by a flush pulse instead of reset.
    load_ten_two_inflight();
    flush   = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'hEE;
    m_ready = 1'b1;
    #1;
    check("fl_ready", s_ready, 1);
    check("fl_no_we", ram_we, 0);
    check("fl_no_re", ram_re, 0);
    tick();
    flush   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    check("fl_valid", m_valid, 0);
    check("fl_level", level, 0);
    tick();
    tick();
    check("fl_stale_drop", level, 0);
    first_word_3c("after_flush");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case a bounded loop is ever bypassed.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
